// File: rtl/jstk2_poll_scheduler_if.sv
// jstk2_poll_scheduler_if
//   Bundles the signals between the joystick poll scheduler, the SPI frame
//   engine and the steering blocks. Suffixes are seen from the scheduler.
//   en_i           polling enable (level)
//   spi_done_i     one-cycle frame-complete pulse from the SPI engine
//   rx_x_i/rx_y_i  raw 10-bit positions, valid with spi_done_i
//   spi_start_o    one-cycle pulse that launches one SPI frame
//   x_val_o/y_val_o latched positions for the steering blocks
//   sample_valid_o one-cycle pulse when x_val_o/y_val_o take a new frame
//   servo_en_o     high while the positions can be trusted
//   err_cnt_o      saturating count of frame timeouts
// Modports: slave = the scheduler, master = whatever drives it.
interface jstk2_poll_scheduler_if;
  logic       en_i;
  logic       spi_done_i;
  logic [9:0] rx_x_i;
  logic [9:0] rx_y_i;
  logic       spi_start_o;
  logic [9:0] x_val_o;
  logic [9:0] y_val_o;
  logic       sample_valid_o;
  logic       servo_en_o;
  logic [7:0] err_cnt_o;

  modport slave (
    input  en_i, spi_done_i, rx_x_i, rx_y_i,
    output spi_start_o, x_val_o, y_val_o, sample_valid_o, servo_en_o, err_cnt_o
  );

  modport master (
    output en_i, spi_done_i, rx_x_i, rx_y_i,
    input  spi_start_o, x_val_o, y_val_o, sample_valid_o, servo_en_o, err_cnt_o
  );
endinterface

// File: rtl/jstk2_poll_scheduler.sv
// jstk2_poll_scheduler
//   Polls a joystick over SPI at a fixed period, latches the returned X/Y
//   positions and drops the steering into a centred failsafe after too many
//   consecutive frames go unanswered.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   js_if  scheduler side (slave modport) of jstk2_poll_scheduler_if
// Parameters:
//   POLL_PERIOD_CYC  cycles between spi_start pulses (> TIMEOUT_CYC + 4)
//   TIMEOUT_CYC      cycles to wait for spi_done (>= 2)
//   MAX_FAIL         consecutive timeouts that force failsafe (1..15)
module jstk2_poll_scheduler #(
  parameter int POLL_PERIOD_CYC = 1_000_000,
  parameter int TIMEOUT_CYC     = 50_000,
  parameter int MAX_FAIL        = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  jstk2_poll_scheduler_if.slave js_if
);

  localparam int PW = $clog2(POLL_PERIOD_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC);

  localparam logic [9:0] CENTRE = 10'd512;

  // The ISSUE cycle of the next frame is itself the last cycle of the
  // current period, so WAIT_PERIOD leaves one count early to keep spi_start
  // rising edges exactly POLL_PERIOD_CYC apart.
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(POLL_PERIOD_CYC - 2);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    FAIL_LIMIT   = 4'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_UPDATE,
    S_TIMEOUT,
    S_WAIT_PERIOD
  } state_t;

  state_t        state_q;
  logic [PW-1:0] period_q;
  logic [TW-1:0] done_tmr_q;
  logic [3:0]    fail_q;
  logic [9:0]    cap_x_q;
  logic [9:0]    cap_y_q;
  logic [9:0]    x_val_q;
  logic [9:0]    y_val_q;
  logic          spi_start_q;
  logic          sample_valid_q;
  logic          servo_en_q;
  logic [7:0]    err_cnt_q;

  logic [7:0]    err_cnt_d;
  logic [3:0]    fail_d;

  // Saturating next values used by the TIMEOUT state.
  assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  assign fail_d    = (fail_q == FAIL_LIMIT) ? fail_q : fail_q + 4'd1;

  // Poll FSM with all outputs registered. rx data is captured on the
  // spi_done cycle because the SPI engine only guarantees it there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      period_q       <= '0;
      done_tmr_q     <= '0;
      fail_q         <= '0;
      cap_x_q        <= '0;
      cap_y_q        <= '0;
      x_val_q        <= CENTRE;
      y_val_q        <= CENTRE;
      spi_start_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      servo_en_q     <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      spi_start_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (js_if.en_i) state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          spi_start_q <= 1'b1;
          done_tmr_q  <= '0;
          period_q    <= '0;
          state_q     <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          period_q   <= period_q + PW'(1);
          done_tmr_q <= done_tmr_q + TW'(1);
          if (js_if.spi_done_i) begin
            cap_x_q <= js_if.rx_x_i;
            cap_y_q <= js_if.rx_y_i;
            state_q <= S_UPDATE;
          end else if (done_tmr_q == TIMEOUT_LAST) begin
            state_q <= S_TIMEOUT;
          end
        end
        S_UPDATE: begin
          period_q       <= period_q + PW'(1);
          x_val_q        <= cap_x_q;
          y_val_q        <= cap_y_q;
          sample_valid_q <= 1'b1;
          servo_en_q     <= 1'b1;
          fail_q         <= '0;
          state_q        <= js_if.en_i ? S_WAIT_PERIOD : S_IDLE;
        end
        S_TIMEOUT: begin
          period_q  <= period_q + PW'(1);
          err_cnt_q <= err_cnt_d;
          fail_q    <= fail_d;
          if (fail_d == FAIL_LIMIT) begin
            x_val_q    <= CENTRE;
            y_val_q    <= CENTRE;
            servo_en_q <= 1'b0;
          end
          state_q <= js_if.en_i ? S_WAIT_PERIOD : S_IDLE;
        end
        S_WAIT_PERIOD: begin
          if (period_q == PERIOD_LAST) begin
            state_q <= js_if.en_i ? S_ISSUE : S_IDLE;
          end else begin
            period_q <= period_q + PW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign js_if.spi_start_o    = spi_start_q;
  assign js_if.x_val_o        = x_val_q;
  assign js_if.y_val_o        = y_val_q;
  assign js_if.sample_valid_o = sample_valid_q;
  assign js_if.servo_en_o     = servo_en_q;
  assign js_if.err_cnt_o      = err_cnt_q;

endmodule
